// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: dual-issue circular instruction queue between fetch and two decoder lanes
module inst_fetch_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [1:0]                 enq_valid_i,
  input  logic [XLEN-1:0]            enq_inst0_i,
  input  logic [XLEN-1:0]            enq_pc0_i,
  input  logic [XLEN-1:0]            enq_inst1_i,
  input  logic [XLEN-1:0]            enq_pc1_i,
  output logic                       enq_ready_o,
  output logic [1:0]                 deq_valid_o,
  output logic [XLEN-1:0]            deq_inst0_o,
  output logic [XLEN-1:0]            deq_pc0_o,
  output logic [XLEN-1:0]            deq_inst1_o,
  output logic [XLEN-1:0]            deq_pc1_o,
  input  logic [1:0]                 deq_ack_i,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h00000013);
  logic [XLEN-1:0] inst_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, head1, tail1;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    n_enq, n_deq;
  always_comb begin
    head1       = head_q + AW'(1);
    tail1       = tail_q + AW'(1);
    enq_ready_o = (FULL - count_q) >= (AW+1)'(2);
    deq_valid_o = {count_q >= (AW+1)'(2), count_q != '0};
    n_enq       = !enq_ready_o ? 2'd0 : enq_valid_i == 2'b11 ? 2'd2 : enq_valid_i == 2'b01 ? 2'd1 : 2'd0;
    n_deq       = (deq_ack_i[0] & deq_valid_o[0]) ? 2'd1 + {1'b0, deq_ack_i[1] & deq_valid_o[1]} : 2'd0;
    head_d      = flush_i ? '0 : head_q + AW'(n_deq);
    tail_d      = flush_i ? '0 : tail_q + AW'(n_enq);
    count_d     = flush_i ? '0 : count_q + (AW+1)'(n_enq) - (AW+1)'(n_deq);
    deq_inst0_o = deq_valid_o[0] ? inst_q[head_q] : NOP;
    deq_pc0_o   = deq_valid_o[0] ? pc_q[head_q]   : '0;
    deq_inst1_o = deq_valid_o[1] ? inst_q[head1]  : NOP;
    deq_pc1_o   = deq_valid_o[1] ? pc_q[head1]    : '0;
    count_o     = count_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // Storage is intentionally unreset; validity comes solely from count.
  always_ff @(posedge clk) begin
    if (!flush_i && n_enq != 2'd0) begin
      inst_q[tail_q] <= enq_inst0_i;
      pc_q[tail_q]   <= enq_pc0_i;
    end
    if (!flush_i && n_enq == 2'd2) begin
      inst_q[tail1] <= enq_inst1_i;
      pc_q[tail1]   <= enq_pc1_i;
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;
  logic        clk, rst, flush_i, enq_ready_o;
  logic [1:0]  enq_valid_i, deq_valid_o, deq_ack_i;
  logic [31:0] enq_inst0_i, enq_pc0_i, enq_inst1_i, enq_pc1_i;
  logic [31:0] deq_inst0_o, deq_pc0_o, deq_inst1_o, deq_pc1_o;
  logic [3:0]  count_o;
  int tests = 0, fails = 0;

  inst_fetch_queue #(.DEPTH(8), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .enq_valid_i(enq_valid_i), .enq_inst0_i(enq_inst0_i), .enq_pc0_i(enq_pc0_i),
    .enq_inst1_i(enq_inst1_i), .enq_pc1_i(enq_pc1_i), .enq_ready_o(enq_ready_o),
    .deq_valid_o(deq_valid_o), .deq_inst0_o(deq_inst0_o), .deq_pc0_o(deq_pc0_o),
    .deq_inst1_o(deq_inst1_o), .deq_pc1_o(deq_pc1_o), .deq_ack_i(deq_ack_i),
    .count_o(count_o)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] ev, input logic [31:0] pc, input logic [1:0] ack, input logic fl);
    enq_valid_i = ev;
    enq_pc0_i   = pc;
    enq_inst0_i = inst_of(pc);
    enq_pc1_i   = pc + 4;
    enq_inst1_i = inst_of(pc + 4);
    deq_ack_i   = ack;
    flush_i     = fl;
    @(posedge clk);
    #1;
    enq_valid_i = 2'b00;
    deq_ack_i   = 2'b00;
    flush_i     = 1'b0;
  endtask

  initial begin
    rst = 1; flush_i = 0; enq_valid_i = 0; deq_ack_i = 0;
    enq_inst0_i = 0; enq_pc0_i = 0; enq_inst1_i = 0; enq_pc1_i = 0;
    #2;
    chk("rst_count", count_o, 0);
    chk("rst_valid", deq_valid_o, 0);
    chk("rst_inst0", deq_inst0_o, 32'h13);
    chk("rst_inst1", deq_inst1_o, 32'h13);
    chk("rst_pc0", deq_pc0_o, 0);
    chk("rst_ready", enq_ready_o, 1);
    rst = 0;
    // ordering and count=1 boundary
    enq_valid_i = 2'b11; enq_inst0_i = 32'h00500093; enq_pc0_i = 0;
    enq_inst1_i = 32'h00A00113; enq_pc1_i = 4;
    @(posedge clk); #1; enq_valid_i = 0;
    chk("ord_count2", count_o, 2);
    chk("ord_valid", deq_valid_o, 2'b11);
    chk("ord_pc0", deq_pc0_o, 0);
    chk("ord_inst0", deq_inst0_o, 32'h00500093);
    chk("ord_pc1", deq_pc1_o, 4);
    chk("ord_inst1", deq_inst1_o, 32'h00A00113);
    cyc(2'b00, 0, 2'b01, 0);
    chk("ord_count1", count_o, 1);
    chk("ord_pc0_next", deq_pc0_o, 4);
    chk("ord_inst0_next", deq_inst0_o, 32'h00A00113);
    chk("one_valid", deq_valid_o, 2'b01);
    chk("one_inst1_nop", deq_inst1_o, 32'h13);
    chk("one_pc1_zero", deq_pc1_o, 0);
    cyc(2'b00, 0, 2'b01, 0);
    chk("drain_count", count_o, 0);
    // fill to DEPTH
    for (int k = 0; k < 4; k++) begin
      if (k == 3) chk("full_ready_at6", enq_ready_o, 1);
      cyc(2'b11, 32'h100 + 8 * k, 2'b00, 0);
    end
    chk("full_count", count_o, 8);
    chk("full_ready", enq_ready_o, 0);
    cyc(2'b11, 32'h300, 2'b00, 0);
    chk("full_ignore_count", count_o, 8);
    chk("full_ignore_pc0", deq_pc0_o, 32'h100);
    for (int k = 0; k < 4; k++) begin
      chk("full_drain_pc0", deq_pc0_o, 32'h100 + 8 * k);
      chk("full_drain_pc1", deq_pc1_o, 32'h104 + 8 * k);
      cyc(2'b00, 0, 2'b11, 0);
    end
    chk("full_drain_count", count_o, 0);
    chk("full_drain_valid", deq_valid_o, 0);
    // wrap: move head to 6, then fill across the end of storage
    cyc(2'b11, 32'h180, 2'b00, 0);
    cyc(2'b11, 32'h188, 2'b00, 0);
    cyc(2'b00, 0, 2'b11, 0);
    cyc(2'b00, 0, 2'b11, 0);
    chk("wrap_empty", count_o, 0);
    for (int k = 0; k < 3; k++) cyc(2'b11, 32'h200 + 8 * k, 2'b00, 0);
    chk("wrap_count6", count_o, 6);
    chk("wrap_pc0", deq_pc0_o, 32'h200);
    cyc(2'b11, 32'h218, 2'b11, 0);
    chk("wrap_simul_count", count_o, 6);
    for (int k = 0; k < 3; k++) begin
      chk("wrap_pc0_ord", deq_pc0_o, 32'h208 + 8 * k);
      chk("wrap_pc1_ord", deq_pc1_o, 32'h20C + 8 * k);
      chk("wrap_inst1_ord", deq_inst1_o, inst_of(32'h20C + 8 * k));
      cyc(2'b00, 0, 2'b11, 0);
    end
    chk("wrap_drain_count", count_o, 0);
    // flush discards simultaneous enqueue and dequeue
    cyc(2'b11, 32'h400, 2'b00, 0);
    cyc(2'b11, 32'h408, 2'b00, 0);
    cyc(2'b01, 32'h410, 2'b00, 0);
    chk("flush_pre_count", count_o, 5);
    cyc(2'b11, 32'h480, 2'b11, 1);
    chk("flush_count", count_o, 0);
    chk("flush_valid", deq_valid_o, 0);
    chk("flush_inst0", deq_inst0_o, 32'h13);
    chk("flush_ready", enq_ready_o, 1);
    cyc(2'b11, 32'h500, 2'b00, 0);
    chk("post_flush_count", count_o, 2);
    chk("post_flush_pc0", deq_pc0_o, 32'h500);
    // illegal patterns and count=7 boundary
    cyc(2'b10, 32'h600, 2'b00, 0);
    chk("ill_enq_count", count_o, 2);
    chk("ill_enq_pc1", deq_pc1_o, 32'h504);
    cyc(2'b01, 32'h508, 2'b00, 0);
    cyc(2'b00, 0, 2'b10, 0);
    chk("ill_ack_count", count_o, 3);
    chk("ill_ack_pc0", deq_pc0_o, 32'h500);
    cyc(2'b11, 32'h510, 2'b00, 0);
    cyc(2'b11, 32'h518, 2'b00, 0);
    chk("cnt7_count", count_o, 7);
    chk("cnt7_ready", enq_ready_o, 0);
    cyc(2'b01, 32'h520, 2'b00, 0);
    chk("cnt7_ignore", count_o, 7);
    cyc(2'b00, 0, 2'b11, 0);
    cyc(2'b00, 0, 2'b01, 0);
    chk("pre_rst_count", count_o, 4);
    chk("pre_rst_pc0", deq_pc0_o, 32'h510);
    // async reset between edges
    #2 rst = 1;
    #1;
    chk("arst_valid", deq_valid_o, 0);
    chk("arst_count", count_o, 0);
    chk("arst_inst1", deq_inst1_o, 32'h13);
    #1 rst = 0;
    cyc(2'b01, 32'h700, 2'b00, 0);
    chk("post_rst_count", count_o, 1);
    chk("post_rst_pc0", deq_pc0_o, 32'h700);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
